// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR keystream controller and its deserialiser.
package lfsr_pkg;

    localparam int SEED_W = 80;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WARMUP = 3'd2,
        ST_GEN    = 3'd3,
        ST_OUT    = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/ks_deser.sv
// MSB-first serial-to-parallel byte register with a 3-bit bit counter.
module ks_deser
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              clr,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_full
);

    logic [2:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            byte_out <= '0;
            bit_cnt  <= '0;
        end else if (bit_en) begin
            byte_out <= {byte_out[BYTE_W-2:0], bit_in};
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // High in the cycle whose bit completes the byte, so the caller can leave GEN on that edge.
    assign byte_full = bit_en && (bit_cnt == 3'd7);

endmodule

// File: rtl/lfsr_keystream_ctrl.sv
// Sequencer that loads the LFSR, discards a warm-up run and emits keystream bytes over valid/ready.
module lfsr_keystream_ctrl
    import lfsr_pkg::*;
#(
    parameter int WARMUP = 160,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SEED_W-1:0] seed_in,
    input  logic [CNT_W-1:0]  num_bytes,
    output logic              lfsr_par_load,
    output logic              lfsr_shift_en,
    output logic [SEED_W-1:0] lfsr_seed,
    input  logic              lfsr_ser_out,
    output logic [BYTE_W-1:0] ks_byte,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [31:0] WARM_LAST = (WARMUP > 0) ? 32'(WARMUP - 1) : 32'd0;

    // Handshake: a byte transfers on a rising edge where ks_valid and ks_ready are
    // both high; ks_valid never drops and ks_byte never changes until that edge
    // (only abort or reset can withdraw it).
    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [31:0]      warm_cnt;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             handshake;
    logic             byte_full;
    logic             bit_en;
    logic             deser_clr;

    assign accept    = (state == ST_IDLE) && start && !abort;
    assign handshake = (state == ST_OUT) && ks_ready && !abort;
    assign bit_en    = (state == ST_GEN);
    assign deser_clr = (state == ST_IDLE) || abort;

    always_comb begin
        state_nxt = state;
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept && num_bytes != '0) state_nxt = ST_LOAD;
                ST_LOAD:   state_nxt = (WARMUP == 0) ? ST_GEN : ST_WARMUP;
                ST_WARMUP: if (warm_cnt == WARM_LAST) state_nxt = ST_GEN;
                ST_GEN:    if (byte_full) state_nxt = ST_OUT;
                ST_OUT:    if (ks_ready) state_nxt = (remaining == CNT_W'(1)) ? ST_IDLE : ST_GEN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so every one of them comes straight from a flop.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            warm_cnt      <= '0;
            remaining     <= '0;
            lfsr_seed     <= '0;
            lfsr_par_load <= 1'b0;
            lfsr_shift_en <= 1'b0;
            ks_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            lfsr_par_load <= (state_nxt == ST_LOAD);
            lfsr_shift_en <= (state_nxt == ST_WARMUP) || (state_nxt == ST_GEN);
            ks_valid      <= (state_nxt == ST_OUT);
            busy          <= (state_nxt != ST_IDLE);
            done          <= (accept && num_bytes == '0) ||
                             (handshake && remaining == CNT_W'(1));
            warm_cnt      <= (state == ST_WARMUP) ? warm_cnt + 32'd1 : 32'd0;
            if (accept) begin
                lfsr_seed <= seed_in;
                remaining <= num_bytes;
            end else if (handshake) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    ks_deser u_deser (
        .clk      (Clk),
        .reset    (reset),
        .bit_in   (lfsr_ser_out),
        .bit_en   (bit_en),
        .clr      (deser_clr),
        .byte_out (ks_byte),
        .byte_full(byte_full)
    );

endmodule
